// File: rtl/parking_gate_if.sv
// Parking gate controller signal bundle: debounced sensor/keypad inputs and gate/status outputs.
interface parking_gate_if #(
   parameter int unsigned CNT_W = 4
);
   logic             sensor_entrance;
   logic             sensor_exit;
   logic             key_enter;
   logic [3:0]       key_code;
   logic             gate_open;
   logic             green_led;
   logic             red_led;
   logic [CNT_W-1:0] occupancy;
   logic             full;

   // Environment side: drives sensors/keypad, observes gate and status.
   modport master (
      output sensor_entrance,
      output sensor_exit,
      output key_enter,
      output key_code,
      input  gate_open,
      input  green_led,
      input  red_led,
      input  occupancy,
      input  full
   );

   // Controller side.
   modport slave (
      input  sensor_entrance,
      input  sensor_exit,
      input  key_enter,
      input  key_code,
      output gate_open,
      output green_led,
      output red_led,
      output occupancy,
      output full
   );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Barrier-gate controller: admission FSM with password check and timeout,
// lot occupancy tracking, and Moore-decoded gate/LED outputs.
module parking_gate_ctrl #(
   parameter int unsigned CAPACITY    = 8,
   parameter int unsigned CNT_W       = 4,
   parameter logic [3:0]  PASS_CODE   = 4'b1011,
   parameter int unsigned TIMEOUT_CYC = 250_000_000,
   parameter int unsigned DENY_CYC    = 100_000_000
) (
   input  logic           clk,
   input  logic           rst_n,
   parking_gate_if.slave  bus
);

   localparam int unsigned TMR_W = 32;
   localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [TMR_W-1:0] DENY_LAST    = TMR_W'(DENY_CYC - 1);
   localparam logic [CNT_W-1:0] CAP_VAL      = CNT_W'(CAPACITY);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_PASS = 3'd1,
      ST_ADMIT     = 3'd2,
      ST_DENY      = 3'd3,
      ST_EXIT_OPEN = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_next_state;

   logic               r_ent_prev;
   logic               r_exit_prev;
   logic               r_key_prev;
   logic               w_ent_rise;
   logic               w_ent_fall;
   logic               w_exit_rise;
   logic               w_exit_fall;
   logic               w_key_rise;

   logic [TMR_W-1:0]   r_timer;
   logic [TMR_W-1:0]   w_timer_next;

   logic [CNT_W-1:0]   r_occ;
   logic [CNT_W-1:0]   w_occ_next;
   logic               w_occ_inc;
   logic               w_occ_dec;
   logic               w_full;
   logic               w_full_next;
   logic               w_occ_nonzero;
   logic               w_code_ok;

   logic               r_gate_open;
   logic               r_green_led;
   logic               r_red_led;
   logic               r_full;
   logic               w_gate_open_next;
   logic               w_green_led_next;
   logic               w_red_led_next;

   // Edge detection from one previous-value register per input.
   assign w_ent_rise  =  bus.sensor_entrance & ~r_ent_prev;
   assign w_ent_fall  = ~bus.sensor_entrance &  r_ent_prev;
   assign w_exit_rise =  bus.sensor_exit     & ~r_exit_prev;
   assign w_exit_fall = ~bus.sensor_exit     &  r_exit_prev;
   assign w_key_rise  =  bus.key_enter       & ~r_key_prev;

   assign w_full        = (r_occ == CAP_VAL);
   assign w_occ_nonzero = (r_occ != '0);
   assign w_code_ok     = (bus.key_code == PASS_CODE);

   // Previous-value registers; cleared at reset so a level high at release reads as a rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ent_prev  <= 1'b0;
         r_exit_prev <= 1'b0;
         r_key_prev  <= 1'b0;
      end else begin
         r_ent_prev  <= bus.sensor_entrance;
         r_exit_prev <= bus.sensor_exit;
         r_key_prev  <= bus.key_enter;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic and occupancy update requests.
   always_comb begin
      w_next_state = r_state;
      w_occ_inc    = 1'b0;
      w_occ_dec    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Exit wins over a simultaneous entrance rise; entrance rise is dropped.
            if (w_exit_rise && w_occ_nonzero) begin
               w_next_state = ST_EXIT_OPEN;
            end else if (w_ent_rise && !w_full) begin
               w_next_state = ST_WAIT_PASS;
            end else if (w_ent_rise && w_full) begin
               w_next_state = ST_DENY;
            end
         end
         ST_WAIT_PASS: begin
            // A key press on the final timeout cycle still counts.
            if (w_key_rise) begin
               w_next_state = w_code_ok ? ST_ADMIT : ST_DENY;
            end else if (r_timer == TIMEOUT_LAST) begin
               w_next_state = ST_IDLE;
            end
         end
         ST_ADMIT: begin
            if (w_ent_fall) begin
               w_next_state = ST_IDLE;
               w_occ_inc    = 1'b1;
            end
         end
         ST_DENY: begin
            if (r_timer == DENY_LAST) begin
               w_next_state = ST_IDLE;
            end
         end
         ST_EXIT_OPEN: begin
            if (w_exit_fall) begin
               w_next_state = ST_IDLE;
               w_occ_dec    = 1'b1;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Timer: counts only while staying in WAIT_PASS or DENY, cleared otherwise.
   always_comb begin
      w_timer_next = '0;
      if ((w_next_state == r_state) &&
          ((r_state == ST_WAIT_PASS) || (r_state == ST_DENY))) begin
         w_timer_next = r_timer + TMR_W'(1);
      end
   end

   // Timer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timer <= '0;
      end else begin
         r_timer <= w_timer_next;
      end
   end

   // Occupancy next value; bounds guard keeps the counter from wrapping.
   always_comb begin
      w_occ_next = r_occ;
      if (w_occ_inc && (r_occ != CAP_VAL)) begin
         w_occ_next = r_occ + CNT_W'(1);
      end else if (w_occ_dec && w_occ_nonzero) begin
         w_occ_next = r_occ - CNT_W'(1);
      end
   end

   // Occupancy register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_occ <= '0;
      end else begin
         r_occ <= w_occ_next;
      end
   end

   // Moore decode of the upcoming state, registered so outputs track the state register.
   always_comb begin
      w_full_next      = (w_occ_next == CAP_VAL);
      w_gate_open_next = (w_next_state == ST_ADMIT) || (w_next_state == ST_EXIT_OPEN);
      w_green_led_next = (w_next_state == ST_ADMIT);
      w_red_led_next   = (w_next_state == ST_DENY) ||
                         ((w_next_state == ST_IDLE) && w_full_next);
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gate_open <= 1'b0;
         r_green_led <= 1'b0;
         r_red_led   <= 1'b0;
         r_full      <= 1'b0;
      end else begin
         r_gate_open <= w_gate_open_next;
         r_green_led <= w_green_led_next;
         r_red_led   <= w_red_led_next;
         r_full      <= w_full_next;
      end
   end

   assign bus.gate_open = r_gate_open;
   assign bus.green_led = r_green_led;
   assign bus.red_led   = r_red_led;
   assign bus.occupancy = r_occ;
   assign bus.full      = r_full;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl against a deadline-based behavioural model.
module tb_parking_gate_ctrl;

   localparam int unsigned CAPACITY    = 2;
   localparam int unsigned CNT_W       = 4;
   localparam logic [3:0]  PASS_CODE   = 4'hB;
   localparam int unsigned TIMEOUT_CYC = 20;
   localparam int unsigned DENY_CYC    = 5;

   localparam int M_IDLE  = 0;
   localparam int M_WAIT  = 1;
   localparam int M_ADMIT = 2;
   localparam int M_DENY  = 3;
   localparam int M_EXIT  = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int total = 0;
   int bad   = 0;

   // Model: mode, car count, absolute cycle index and the cycle at which a timed mode ends.
   int m_mode;
   int m_occ;
   int m_cyc;
   int m_deadline;
   bit m_pe, m_px, m_pk;

   always #5 clk = ~clk;

   parking_gate_if #(.CNT_W(CNT_W)) bus ();

   parking_gate_ctrl #(
      .CAPACITY   (CAPACITY),
      .CNT_W      (CNT_W),
      .PASS_CODE  (PASS_CODE),
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .DENY_CYC   (DENY_CYC)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   function automatic logic [7:0] exp_vec();
      logic g, gr, r, f;
      g  = (m_mode == M_ADMIT) || (m_mode == M_EXIT);
      gr = (m_mode == M_ADMIT);
      f  = (m_occ == int'(CAPACITY));
      r  = (m_mode == M_DENY) || ((m_mode == M_IDLE) && f);
      return {g, gr, r, f, 4'(m_occ)};
   endfunction

   function automatic logic [7:0] obs_vec();
      return {bus.gate_open, bus.green_led, bus.red_led, bus.full, bus.occupancy};
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_occ = 0; m_cyc = 0; m_deadline = 0;
      m_pe = 0; m_px = 0; m_pk = 0;
   endtask

   task automatic model_step();
      bit re, fe, rx, fx, rk;
      re = bus.sensor_entrance && !m_pe;
      fe = !bus.sensor_entrance && m_pe;
      rx = bus.sensor_exit && !m_px;
      fx = !bus.sensor_exit && m_px;
      rk = bus.key_enter && !m_pk;
      m_cyc++;
      case (m_mode)
         M_IDLE: begin
            if (rx && m_occ > 0) m_mode = M_EXIT;
            else if (re && m_occ < int'(CAPACITY)) begin
               m_mode = M_WAIT; m_deadline = m_cyc + int'(TIMEOUT_CYC);
            end else if (re) begin
               m_mode = M_DENY; m_deadline = m_cyc + int'(DENY_CYC);
            end
         end
         M_WAIT: begin
            if (rk && bus.key_code == PASS_CODE) m_mode = M_ADMIT;
            else if (rk) begin
               m_mode = M_DENY; m_deadline = m_cyc + int'(DENY_CYC);
            end else if (m_cyc == m_deadline) m_mode = M_IDLE;
         end
         M_ADMIT: if (fe) begin m_mode = M_IDLE; m_occ++; end
         M_EXIT:  if (fx) begin m_mode = M_IDLE; m_occ--; end
         M_DENY:  if (m_cyc == m_deadline) m_mode = M_IDLE;
         default: m_mode = M_IDLE;
      endcase
      m_pe = bus.sensor_entrance;
      m_px = bus.sensor_exit;
      m_pk = bus.key_enter;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic admit_car();
      bus.sensor_entrance = 1'b1; tick();
      bus.key_code = PASS_CODE; bus.key_enter = 1'b1; tick();
      bus.key_enter = 1'b0; bus.sensor_entrance = 1'b0; tick();
      tick();
   endtask

   task automatic test_reset();
      bus.sensor_entrance = 1'b0; bus.sensor_exit = 1'b0;
      bus.key_enter = 1'b0; bus.key_code = 4'h0;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (obs_vec() !== 8'h00) begin
         bad++; $display("FAIL reset_state: got %b want %b", obs_vec(), 8'h00);
      end
      rst_n = 1'b1;
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL reset_release: got %b want %b", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_admit();
      bus.sensor_entrance = 1'b1; tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL admit_wait: got %b want %b", obs_vec(), exp_vec());
      end
      bus.key_code = 4'hB; bus.key_enter = 1'b1; tick();
      total++;
      if ({bus.gate_open, bus.green_led} !== 2'b11 || obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL admit_open: got %b want %b", obs_vec(), exp_vec());
      end
      bus.key_enter = 1'b0; bus.sensor_entrance = 1'b0; tick();
      total++;
      if (bus.occupancy !== 4'd1 || bus.gate_open !== 1'b0 || obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL admit_done: got %b want %b", obs_vec(), exp_vec());
      end
      tick();
   endtask

   task automatic test_wrong_code();
      int red_cnt;
      red_cnt = 0;
      bus.sensor_entrance = 1'b1; tick();
      bus.sensor_entrance = 1'b0;
      bus.key_code = 4'h3; bus.key_enter = 1'b1; tick();
      bus.key_enter = 1'b0;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL deny_seq[%0d]: got %b want %b", i, obs_vec(), exp_vec());
         end
         if (bus.red_led === 1'b1) red_cnt++;
         tick();
      end
      total++;
      if (red_cnt !== 5 || bus.occupancy !== 4'd1) begin
         bad++; $display("FAIL deny_len: red cycles %0d occ %0d want 5 and 1", red_cnt, bus.occupancy);
      end
   endtask

   task automatic test_timeout();
      // Press one cycle after the window closes: must be ignored.
      bus.sensor_entrance = 1'b1; tick();
      bus.sensor_entrance = 1'b0;
      for (int i = 0; i < int'(TIMEOUT_CYC); i++) begin
         tick();
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL timeout_seq[%0d]: got %b want %b", i, obs_vec(), exp_vec());
         end
      end
      bus.key_code = PASS_CODE; bus.key_enter = 1'b1; tick();
      bus.key_enter = 1'b0;
      total++;
      if (bus.gate_open !== 1'b0 || obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL timeout_expired: got %b want %b", obs_vec(), exp_vec());
      end
      tick();
      // Press on the last cycle of the window: admits.
      bus.sensor_entrance = 1'b1; tick();
      bus.sensor_entrance = 1'b0;
      repeat (int'(TIMEOUT_CYC) - 1) tick();
      bus.key_code = PASS_CODE; bus.key_enter = 1'b1; tick();
      bus.key_enter = 1'b0;
      total++;
      if ({bus.gate_open, bus.green_led} !== 2'b11 || obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL timeout_last_admit: got %b want %b", obs_vec(), exp_vec());
      end
      bus.sensor_entrance = 1'b1; tick();
      bus.sensor_entrance = 1'b0; tick();
      total++;
      if (bus.occupancy !== 4'd2 || obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL timeout_occ: got %b want %b", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_full();
      tick();
      total++;
      if ({bus.red_led, bus.full} !== 2'b11 || obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL full_idle: got %b want %b", obs_vec(), exp_vec());
      end
      bus.sensor_entrance = 1'b1; tick();
      bus.sensor_entrance = 1'b0;
      total++;
      if ({bus.gate_open, bus.red_led} !== 2'b01 || obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL full_deny: got %b want %b", obs_vec(), exp_vec());
      end
      repeat (6) tick();
      total++;
      if (bus.occupancy !== 4'd2 || obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL full_occ: got %b want %b", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_exit_priority();
      bus.sensor_exit = 1'b1; tick();
      bus.sensor_exit = 1'b0; tick();
      total++;
      if (bus.occupancy !== 4'd1 || obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL exit_one: got %b want %b", obs_vec(), exp_vec());
      end
      bus.sensor_entrance = 1'b1; bus.sensor_exit = 1'b1; tick();
      total++;
      if ({bus.gate_open, bus.green_led} !== 2'b10 || obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL prio_exit_open: got %b want %b", obs_vec(), exp_vec());
      end
      bus.sensor_exit = 1'b0; tick();
      total++;
      if (bus.occupancy !== 4'd0 || bus.gate_open !== 1'b0 || obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL prio_exit_occ: got %b want %b", obs_vec(), exp_vec());
      end
      bus.sensor_entrance = 1'b0; tick();
      bus.sensor_exit = 1'b1; tick();
      total++;
      if (bus.gate_open !== 1'b0 || obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL exit_empty: got %b want %b", obs_vec(), exp_vec());
      end
      bus.sensor_exit = 1'b0; tick();
   endtask

   task automatic test_reset_mid();
      admit_car();
      bus.sensor_entrance = 1'b1; tick();
      bus.key_code = PASS_CODE; bus.key_enter = 1'b1; tick();
      bus.key_enter = 1'b0;
      total++;
      if (bus.gate_open !== 1'b1 || bus.occupancy !== 4'd1) begin
         bad++; $display("FAIL reset_mid_pre: got %b want gate 1 occ 1", obs_vec());
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (obs_vec() !== 8'h00) begin
         bad++; $display("FAIL reset_mid_outputs: got %b want %b", obs_vec(), 8'h00);
      end
      model_reset();
      #2 rst_n = 1'b1;
      tick();
      bus.key_code = PASS_CODE; bus.key_enter = 1'b1; tick();
      bus.key_enter = 1'b0;
      total++;
      if (bus.gate_open !== 1'b1 || obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL reset_release_wait: got %b want %b", obs_vec(), exp_vec());
      end
      bus.sensor_entrance = 1'b0; tick();
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(5) == 0) bus.sensor_entrance = ~bus.sensor_entrance;
         if ($urandom_range(6) == 0) bus.sensor_exit = ~bus.sensor_exit;
         if ($urandom_range(3) == 0) bus.key_enter = ~bus.key_enter;
         bus.key_code = ($urandom_range(1) == 0) ? PASS_CODE : 4'($urandom_range(15));
         tick();
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL random[%0d]: got %b want %b", i, obs_vec(), exp_vec());
         end
      end
      bus.sensor_entrance = 1'b0; bus.sensor_exit = 1'b0; bus.key_enter = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      test_reset();
      test_admit();
      test_wrong_code();
      test_timeout();
      test_full();
      test_exit_priority();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
